// File: rtl/cg_ctrl.sv
// Clock-enable controller for one CGRA tile: gates the tile clock after a
// programmable idle window and restores it on datapath activity or wake requests.
module cg_ctrl #(
  parameter int unsigned IDLE_W   = 8,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned CG_DELAY = 2,
  parameter int unsigned WAKE_LAT = 1
) (
  input  logic              clkn,
  input  logic              rstn,
  input  logic              enable,
  input  logic              busy,
  input  logic              wake_req,
  input  logic [IDLE_W-1:0] idle_thresh,
  input  logic              stat_clr,
  output logic              clken,
  output logic              gated,
  output logic              wake_ack,
  output logic [CNT_W-1:0]  gated_cycles
);

  localparam int unsigned DRAIN_W = $clog2(CG_DELAY + 1);
  localparam int unsigned WAKE_W  = $clog2(WAKE_LAT + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OFF   = 2'd2,
    ST_WAKE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [WAKE_W-1:0]  wake_cnt_q, wake_cnt_d;
  logic               clken_q, clken_d;
  logic               gated_q, gated_d;
  logic               wake_ack_q, wake_ack_d;
  logic [CNT_W-1:0]   gcnt_q, gcnt_d;

  logic idle_c;
  logic wake_evt_c;
  logic thresh_hit_c;

  // The threshold is compared live so a lowered value takes effect at once.
  assign idle_c       = enable & ~busy & ~wake_req;
  assign wake_evt_c   = busy | wake_req;
  assign thresh_hit_c = (idle_thresh != '0) &&
                        (idle_cnt_q >= (idle_thresh - IDLE_W'(1)));

  // State and output registers; reset keeps the clock running.
  always_ff @(posedge clkn or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_RUN;
      idle_cnt_q  <= '0;
      drain_cnt_q <= '0;
      wake_cnt_q  <= '0;
      clken_q     <= 1'b1;
      gated_q     <= 1'b0;
      wake_ack_q  <= 1'b0;
      gcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      wake_cnt_q  <= wake_cnt_d;
      clken_q     <= clken_d;
      gated_q     <= gated_d;
      wake_ack_q  <= wake_ack_d;
      gcnt_q      <= gcnt_d;
    end
  end

  // Next-state, counters and registered-output decode.
  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    drain_cnt_d = drain_cnt_q;
    wake_cnt_d  = wake_cnt_q;
    clken_d     = 1'b1;
    gated_d     = 1'b0;
    wake_ack_d  = 1'b0;
    gcnt_d      = gcnt_q;

    if (!enable) begin
      state_d     = ST_RUN;
      idle_cnt_d  = '0;
      drain_cnt_d = '0;
      wake_cnt_d  = '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (idle_c) begin
            if (thresh_hit_c) begin
              state_d     = ST_DRAIN;
              idle_cnt_d  = '0;
              drain_cnt_d = '0;
            end else if (idle_cnt_q != '1) begin
              idle_cnt_d = idle_cnt_q + IDLE_W'(1);
            end
          end else begin
            idle_cnt_d = '0;
          end
        end
        ST_DRAIN: begin
          // Wait out the gate cell's switch-off delay before claiming OFF.
          if (wake_evt_c) begin
            state_d     = ST_RUN;
            idle_cnt_d  = '0;
            drain_cnt_d = '0;
          end else if (drain_cnt_q == DRAIN_W'(CG_DELAY - 1)) begin
            state_d     = ST_OFF;
            drain_cnt_d = '0;
          end else begin
            drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
          end
        end
        ST_OFF: begin
          if (wake_evt_c) begin
            state_d    = ST_WAKE;
            wake_cnt_d = '0;
          end
        end
        ST_WAKE: begin
          if (wake_cnt_q == WAKE_W'(WAKE_LAT - 1)) begin
            state_d    = ST_RUN;
            idle_cnt_d = '0;
            wake_cnt_d = '0;
          end else begin
            wake_cnt_d = wake_cnt_q + WAKE_W'(1);
          end
        end
        default: begin
          state_d     = ST_RUN;
          idle_cnt_d  = '0;
          drain_cnt_d = '0;
          wake_cnt_d  = '0;
        end
      endcase
    end

    clken_d    = (state_d == ST_RUN) || (state_d == ST_WAKE);
    gated_d    = (state_d == ST_OFF);
    wake_ack_d = (state_d == ST_RUN) && wake_req;

    // Clear beats a same-cycle increment.
    if (stat_clr) begin
      gcnt_d = '0;
    end else if ((state_q == ST_OFF) && (gcnt_q != '1)) begin
      gcnt_d = gcnt_q + CNT_W'(1);
    end
  end

  assign clken        = clken_q;
  assign gated        = gated_q;
  assign wake_ack     = wake_ack_q;
  assign gated_cycles = gcnt_q;

  // A stopped clock must never coexist with an asserted enable.
  a_gated_no_clken : assert property (@(posedge clkn) disable iff (!rstn)
    gated_q |-> !clken_q);

  // OFF is only ever reached through a full drain.
  a_off_via_drain : assert property (@(posedge clkn) disable iff (!rstn)
    $rose(gated_q) |-> ($past(state_q) == ST_DRAIN));

endmodule
